// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The master drives operands and out_ready; the slave (the adder) returns results.
interface pipelined_adder_if #(
    parameter int unsigned N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined N-bit adder/subtractor: carry chain cut into STAGES chunks with skew/deskew registers.
// Define PIPELINED_ADDER_OVF_EN to build the signed-overflow output; otherwise ovf is tied low.
module pipelined_adder #(
    parameter int unsigned N      = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic               clk,
    input  logic               rst,
    pipelined_adder_if.slave   bus
);
    localparam int unsigned W = N / STAGES;

    logic         adv;
    logic         out_v;
    logic         c0;
    logic [N-1:0] bp;

    // Whole pipe advances together; a stalled output freezes every stage.
    assign out_v        = stg[STAGES-1].v_r;
    assign adv          = !out_v || bus.out_ready;
    assign bus.in_ready = adv;

    assign bp = bus.sub ? ~bus.b : bus.b;
    assign c0 = bus.sub | bus.cin;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        // Operand bits not yet consumed when entering stage k (chunk k sits at the bottom).
        localparam int unsigned RW = N - k * W;

        logic [RW-1:0]        in_a;
        logic [RW-1:0]        in_b;
        logic                 cin_k;
        logic                 v_in;
        logic [W:0]           csum;
        logic [(k+1)*W-1:0]   s_nx;
        logic [(k+1)*W-1:0]   s_r;
        logic                 c_r;
        logic                 v_r;

        if (k == 0) begin : g_head
            assign in_a  = bus.a;
            assign in_b  = bp;
            assign cin_k = c0;
            assign v_in  = bus.in_valid;
            assign s_nx  = csum[W-1:0];
        end else begin : g_body
            assign in_a  = stg[k-1].g_skew.a_r;
            assign in_b  = stg[k-1].g_skew.b_r;
            assign cin_k = stg[k-1].c_r;
            assign v_in  = stg[k-1].v_r;
            assign s_nx  = {csum[W-1:0], stg[k-1].s_r};
        end

        assign csum = {1'b0, in_a[W-1:0]} + {1'b0, in_b[W-1:0]} + (W+1)'(cin_k);

        always_ff @(posedge clk) begin
            if (rst) begin
                s_r <= '0;
                c_r <= 1'b0;
                v_r <= 1'b0;
            end else if (adv) begin
                s_r <= s_nx;
                c_r <= csum[W];
                v_r <= v_in;
            end
        end

        // Upper operand chunks ride along until their stage consumes them.
        if (k < STAGES - 1) begin : g_skew
            logic [RW-W-1:0] a_r;
            logic [RW-W-1:0] b_r;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (adv) begin
                    a_r <= in_a[RW-1:W];
                    b_r <= in_b[RW-1:W];
                end
            end
        end
    end

    assign bus.out_valid = out_v;
    assign bus.sum       = stg[STAGES-1].s_r;
    assign bus.cout      = stg[STAGES-1].c_r;

`ifdef PIPELINED_ADDER_OVF_EN
    logic msb_cin;
    logic ovf_r;

    // Carry into the MSB recovered from its operand bits and sum bit.
    assign msb_cin = stg[STAGES-1].in_a[W-1] ^ stg[STAGES-1].in_b[W-1] ^ stg[STAGES-1].csum[W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (adv) begin
            ovf_r <= msb_cin ^ stg[STAGES-1].csum[W];
        end
    end

    assign bus.ovf = ovf_r;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder: default 32/4 build plus 8/1 and 16/16 corner configurations.
module tb_pipelined_adder;
`ifdef PIPELINED_ADDER_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_adder_if #(.N(32)) bm ();
    pipelined_adder_if #(.N(8))  b8 ();
    pipelined_adder_if #(.N(16)) b16 ();

    pipelined_adder #(.N(32), .STAGES(4))  u_main (.clk(clk), .rst(rst), .bus(bm));
    pipelined_adder #(.N(8),  .STAGES(1))  u_n8   (.clk(clk), .rst(rst), .bus(b8));
    pipelined_adder #(.N(16), .STAGES(16)) u_n16  (.clk(clk), .rst(rst), .bus(b16));

    int npass  = 0;
    int ntotal = 0;
    vec_t vt[6];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive_m(input int i);
        bm.a        = vt[i].a;
        bm.b        = vt[i].b;
        bm.cin      = vt[i].cin;
        bm.sub      = vt[i].sub;
        bm.in_valid = 1'b1;
    endtask

    // One isolated op on the 32/4 instance: exact 4-cycle latency, then drain.
    task automatic single_m(input int i);
        drive_m(i);
        @(negedge clk);
        bm.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("lat_early", 64'(bm.out_valid), 64'(1'b0));
        @(negedge clk);
        chk("lat_valid", 64'(bm.out_valid), 64'(1'b1));
        chk("single_sum", 64'(bm.sum), 64'(vt[i].sum));
        chk("single_cout", 64'(bm.cout), 64'(vt[i].cout));
        chk("single_ovf", 64'(bm.ovf), 64'(vt[i].ovf & OVF_ON));
        @(negedge clk);
        chk("drained", 64'(bm.out_valid), 64'(1'b0));
    endtask

    initial begin
        int rx;
        int tx;
        int first;
        int last;
        int seen;
        logic held;
        logic acc;
        logic [31:0] hold_sum;
        logic [39:0] pat;

        vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vt[1] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vt[2] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        vt[3] = '{32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vt[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vt[5] = '{32'h1234_5678, 32'h0FED_CBA8, 1'b1, 1'b0, 32'h2222_2221, 1'b0, 1'b0};

        bm.in_valid = 1'b0; bm.a = '0; bm.b = '0; bm.cin = 1'b0; bm.sub = 1'b0; bm.out_ready = 1'b1;
        b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0; b8.sub = 1'b0; b8.out_ready = 1'b1;
        b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.cin = 1'b0; b16.sub = 1'b0; b16.out_ready = 1'b1;

        // Reset held for two cycles.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(bm.out_valid), 64'(1'b0));
        chk("rst_sum", 64'(bm.sum), 64'(32'h0));
        chk("rst_cout", 64'(bm.cout), 64'(1'b0));
        chk("rst_ovf", 64'(bm.ovf), 64'(1'b0));
        chk("rst_in_ready", 64'(bm.in_ready), 64'(1'b1));

        single_m(0);
        single_m(1);

        // Back-to-back stream, out_ready held high.
        rx = 0; first = -1; last = -1;
        for (int c = 0; c < 20; c++) begin
            if (c < 6) drive_m(c);
            else bm.in_valid = 1'b0;
            @(negedge clk);
            if (bm.out_valid) begin
                if (rx < 6) begin
                    chk("stream_sum", 64'(bm.sum), 64'(vt[rx].sum));
                    chk("stream_cout", 64'(bm.cout), 64'(vt[rx].cout));
                    chk("stream_ovf", 64'(bm.ovf), 64'(vt[rx].ovf & OVF_ON));
                end
                if (first < 0) first = c;
                last = c;
                rx++;
            end
        end
        chk("stream_count", 64'(rx), 64'(6));
        chk("stream_first", 64'(first), 64'(3));
        chk("stream_contig", 64'(last - first), 64'(5));

        // Stream under a fixed stall pattern on out_ready.
        pat = 40'h5A_C3_96_69_A5;
        rx = 0; tx = 0; held = 1'b0; hold_sum = '0;
        for (int c = 0; c < 40 && rx < 6; c++) begin
            bm.out_ready = pat[c];
            if (tx < 6) drive_m(tx);
            else bm.in_valid = 1'b0;
            #1;
            chk("bp_in_ready", 64'(bm.in_ready), 64'(!(bm.out_valid && !bm.out_ready)));
            if (held) begin
                chk("bp_hold_valid", 64'(bm.out_valid), 64'(1'b1));
                chk("bp_hold_sum", 64'(bm.sum), 64'(hold_sum));
            end
            if (bm.out_valid && bm.out_ready) begin
                chk("bp_sum", 64'(bm.sum), 64'(vt[rx].sum));
                chk("bp_cout", 64'(bm.cout), 64'(vt[rx].cout));
                rx++;
            end
            held     = bm.out_valid && !bm.out_ready;
            hold_sum = bm.sum;
            acc      = bm.in_valid && bm.in_ready;
            @(negedge clk);
            if (acc) tx++;
        end
        chk("bp_count", 64'(rx), 64'(6));
        bm.out_ready = 1'b1;
        bm.in_valid  = 1'b0;
        repeat (6) @(negedge clk);

        // Three ops in flight, then a one-cycle reset discards them.
        for (int i = 0; i < 3; i++) begin
            drive_m(i);
            @(negedge clk);
        end
        bm.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bm.out_valid) seen++;
        end
        chk("mid_rst_no_out", 64'(seen), 64'(0));
        single_m(5);

        // Small configurations: 8/1 (latency 1) and 16/16 (latency 16).
        b8.a = 8'hFF; b8.b = 8'h01; b8.cin = 1'b0; b8.sub = 1'b0; b8.in_valid = 1'b1;
        b16.a = 16'h8000; b16.b = 16'h0001; b16.cin = 1'b0; b16.sub = 1'b1; b16.in_valid = 1'b1;
        #1;
        chk("n8_pre", 64'(b8.out_valid), 64'(1'b0));
        @(negedge clk);
        b8.in_valid = 1'b0; b16.in_valid = 1'b0;
        chk("n8_valid", 64'(b8.out_valid), 64'(1'b1));
        chk("n8_sum", 64'(b8.sum), 64'(8'h00));
        chk("n8_cout", 64'(b8.cout), 64'(1'b1));
        chk("n8_ovf", 64'(b8.ovf), 64'(1'b0));
        repeat (14) @(negedge clk);
        chk("n16_early", 64'(b16.out_valid), 64'(1'b0));
        @(negedge clk);
        chk("n16_valid", 64'(b16.out_valid), 64'(1'b1));
        chk("n16_sum", 64'(b16.sum), 64'(16'h7FFF));
        chk("n16_cout", 64'(b16.cout), 64'(1'b1));
        chk("n16_ovf", 64'(b16.ovf), 64'(OVF_ON));
        chk("n8_drained", 64'(b8.out_valid), 64'(1'b0));
        @(negedge clk);

        // Mid-flight reset on the small configurations.
        b8.out_ready = 1'b0;
        b8.a = 8'h7F; b8.b = 8'h01; b8.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b16.a = 16'(i + 1); b16.b = 16'h0002; b16.sub = 1'b0; b16.in_valid = 1'b1;
            @(negedge clk);
            b8.in_valid = 1'b0;
        end
        b16.in_valid = 1'b0;
        chk("n8_stalled", 64'(b8.out_valid), 64'(1'b1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b8.out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (b8.out_valid || b16.out_valid) seen++;
        end
        chk("small_mid_rst", 64'(seen), 64'(0));

        b8.a = 8'h7F; b8.b = 8'h01; b8.in_valid = 1'b1;
        b16.a = 16'h7FFF; b16.b = 16'h0001; b16.cin = 1'b0; b16.sub = 1'b0; b16.in_valid = 1'b1;
        @(negedge clk);
        b8.in_valid = 1'b0; b16.in_valid = 1'b0;
        chk("n8_r_valid", 64'(b8.out_valid), 64'(1'b1));
        chk("n8_r_sum", 64'(b8.sum), 64'(8'h80));
        chk("n8_r_ovf", 64'(b8.ovf), 64'(OVF_ON));
        repeat (14) @(negedge clk);
        chk("n16_r_early", 64'(b16.out_valid), 64'(1'b0));
        @(negedge clk);
        chk("n16_r_valid", 64'(b16.out_valid), 64'(1'b1));
        chk("n16_r_sum", 64'(b16.sum), 64'(16'h8000));
        chk("n16_r_cout", 64'(b16.cout), 64'(1'b0));
        chk("n16_r_ovf", 64'(b16.ovf), 64'(OVF_ON));

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
